video_stream_gen: RTL and testbench
===================================

# video_stream_gen

Parameterised video timing and test-pattern source. It produces the `{pixel, de, h_sync, v_sync}` stream that the 3x3 context/window stages consume, so the KLT pipeline can run in simulation and on hardware without an external camera. The block generates raster timing counters and a selectable 8-bit pattern. Start and stop are frame-aligned, and all outputs are registered.

## Interface
Parameters:
- `H_ACTIVE`, 1280, active pixels per line
- `H_FP`, 110, horizontal front porch (clk)
- `H_SYNC`, 40, h_sync pulse width (clk)
- `H_BP`, 220, horizontal back porch (clk); total line = 1650
- `V_ACTIVE`, 720, active lines per frame
- `V_FP`, 5, vertical front porch (lines)
- `V_SYNC`, 5, v_sync width (lines)
- `V_BP`, 20, vertical back porch (lines); total frame = 750 lines

Ports:
- `clk`  in  1  pixel clock
- `rst`  in  1  asynchronous, active-high reset
- `enable`  in  1  run request; level-sensitive
- `pattern_sel`  in  2  0 h-ramp, 1 v-ramp, 2 checker, 3 moving ramp
- `pixel_out`  out  8  pattern pixel; 0 when `de_out`=0
- `de_out`  out  1  data enable
- `h_sync_out`  out  1  horizontal sync, active high
- `v_sync_out`  out  1  vertical sync, active high
- `frame_start`  out  1  one-cycle pulse coincident with pixel (0,0)
- `stream_out`  out  11  packed word `{pixel_out, de_out, h_sync_out, v_sync_out}`
- `busy`  out  1  high while the state machine is not in IDLE

## Operation
- Counters `h_cnt` (0..H_TOTAL-1) and `v_cnt` (0..V_TOTAL-1). `h_cnt` wraps to 0 and `v_cnt` increments on `h_cnt` = H_TOTAL-1. `v_cnt` wraps after the last line.
- Line order: active `[0, H_ACTIVE)`, then FP, SYNC, BP. `h_sync` is high for `h_cnt` in `[H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)`.
- Frame order: active lines, then FP, SYNC, BP. `v_sync` is high for the whole of lines `[V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)`. It changes only at `h_cnt` = 0.
- `de` = (`h_cnt` < H_ACTIVE) & (`v_cnt` < V_ACTIVE).
- Patterns are computed from the counters, with widths truncated to 8 bits:
  - 0: `h_cnt[7:0]`
  - 1: `v_cnt[7:0]`
  - 2: `(h_cnt[3]^v_cnt[3]) ? 8'hFF : 8'h00`
  - 3: `(h_cnt + frame_cnt)[7:0]`
- `pattern_sel` is latched at each frame start (counter state (0,0)). A mid-frame change takes effect at the next frame.
- `frame_cnt` is 8 bits. It increments on the last cycle of every frame and wraps 255→0. It resets to 0 and is not cleared by stop/start.
- State machine:
  - IDLE: counters are held at 0 and all outputs are 0. `enable`=1 → RUN.
  - RUN: counters advance. `enable`=0 → STOPPING; the frame is not cut short.
  - STOPPING: counters advance. On the last cycle of the frame → IDLE, or → RUN if `enable` is 1 again on that cycle. `enable` rising mid-STOPPING → RUN with no frame interruption.
- Reset (asynchronous, any time including mid-frame): state IDLE, counters 0, `frame_cnt` 0, latched pattern 0, all outputs 0.

## Timing
- Edge E samples `enable`=1 in IDLE. Counters hold (0,0) after E+1. Outputs show pixel (0,0) with `de_out`=1 and `frame_start`=1 after edge E+2.
- The output stage is one register stage behind the counters. Every output, including `stream_out`, is mutually aligned.
- A back-to-back frame has no gap: the cycle after the last BP cycle is pixel (0,0) of the next frame.
- After stopping, the last BP cycle is followed by outputs going 0 one edge later. `busy` falls together with that edge.
- Period per frame = H_TOTAL × V_TOTAL clk (1 237 500 at defaults).

## Structure
- The shared package holds the stream word layout constants: PIX_MSB=10, PIX_LSB=3, DE_BIT=2, HS_BIT=1, VS_BIT=0. The context stages use the same package.
- Single sub-module: `raster_counter`, which holds `h_cnt`/`v_cnt`, the line/frame-end strobes and the region decode. The top level holds the FSM, pattern mux, frame counter and output registers.

## Test plan
Small parameters for simulation: H 8/2/2/2 (total 14), V 4/1/1/1 (total 7), so frame = 98 clk.
- Reset asserted mid-frame → all outputs are 0 immediately (asynchronous). After release with `enable`=0, outputs stay 0 and `busy`=0.
- `enable`=1 at edge E → `frame_start` and `de_out` go high after E+2. `de_out` is high 8 cycles per line × 4 lines = 32 cycles per 98-cycle frame.
- Sync geometry → `h_sync_out` is high at h 10..11 on every line. `v_sync_out` is high for all 14 cycles of line 5. `stream_out[2:0]` matches the discrete outputs.
- Patterns → sel 0: pixel 0..7 per active line. Sel 1: pixel = line index. Sel 2 with H_ACTIVE=16: pixel 00 for h 0..7 and FF for h 8..15 on line 0. Sel 3 on frame 2: pixel 2..9.
- `pattern_sel` changed mid-frame → output is unchanged until the next `frame_start`.
- `enable` dropped mid-frame → the frame completes (all 98 cycles), then outputs are 0. Raising `enable` in the last cycle of STOPPING → the next frame follows with no gap.

Source files
------------

// File: rtl/video_stream_gen_pkg.sv
// rtl/video_stream_gen_pkg.sv - shared stream word layout, pattern and state types
package video_stream_gen_pkg;

  localparam int PIX_MSB  = 10;
  localparam int PIX_LSB  = 3;
  localparam int DE_BIT   = 2;
  localparam int HS_BIT   = 1;
  localparam int VS_BIT   = 0;
  localparam int STREAM_W = 11;

  typedef enum logic [1:0] {
    PAT_H_RAMP  = 2'd0,
    PAT_V_RAMP  = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_MOVING  = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_e;

  function automatic logic [7:0] pattern_pixel(input pattern_e sel, input logic [7:0] h,
                                               input logic [7:0] v, input logic [7:0] frame);
    logic [7:0] pix;
    case (sel)
      PAT_H_RAMP:  pix = h;
      PAT_V_RAMP:  pix = v;
      PAT_CHECKER: pix = (h[3] ^ v[3]) ? 8'hFF : 8'h00;
      default:     pix = h + frame;
    endcase
    return pix;
  endfunction

endpackage

// File: rtl/video_stream_gen_raster_counter.sv
// rtl/video_stream_gen_raster_counter.sv - h/v raster counters, end strobes and region decode
module raster_counter
  import video_stream_gen_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20,
  parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP + 1),
  parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          frame_end,
  output logic          h_active,
  output logic          v_active,
  output logic          h_sync,
  output logic          v_sync
);

  localparam logic [HW-1:0] H_LAST = HW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic line_end;

  assign line_end  = (h_cnt == H_LAST);
  assign frame_end = line_end && (v_cnt == V_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (advance) begin
      if (line_end) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // v_sync decodes whole lines, so it can only toggle when h_cnt returns to 0
  assign h_active = (h_cnt < H_ACT);
  assign v_active = (v_cnt < V_ACT);
  assign h_sync   = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
  assign v_sync   = (v_cnt >= VS_BEG) && (v_cnt < VS_END);

endmodule

// File: rtl/video_stream_gen.sv
// rtl/video_stream_gen.sv - video timing and test-pattern source with frame-aligned start/stop
module video_stream_gen
  import video_stream_gen_pkg::*;
#(
  parameter int H_ACTIVE = 1280,
  parameter int H_FP     = 110,
  parameter int H_SYNC   = 40,
  parameter int H_BP     = 220,
  parameter int V_ACTIVE = 720,
  parameter int V_FP     = 5,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [1:0]          pattern_sel,
  output logic [7:0]          pixel_out,
  output logic                de_out,
  output logic                h_sync_out,
  output logic                v_sync_out,
  output logic                frame_start,
  output logic [STREAM_W-1:0] stream_out,
  output logic                busy
);

  localparam int HW = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP + 1);
  localparam int VW = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP + 1);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          frame_end, h_active, v_active, h_sync, v_sync;
  logic          cnt_active, frame_last, at_origin, de_d;
  logic [7:0]    h_lo, v_lo, frame_cnt;
  state_e        state, state_next;
  pattern_e      sel_q, sel_cur;

  raster_counter #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HW(HW), .VW(VW)
  ) u_raster (
    .clk      (clk),
    .rst      (rst),
    .advance  (cnt_active),
    .h_cnt    (h_cnt),
    .v_cnt    (v_cnt),
    .frame_end(frame_end),
    .h_active (h_active),
    .v_active (v_active),
    .h_sync   (h_sync),
    .v_sync   (v_sync)
  );

  assign frame_last = cnt_active && frame_end;
  assign at_origin  = (h_cnt == '0) && (v_cnt == '0);
  assign h_lo       = 8'(h_cnt);
  assign v_lo       = 8'(v_cnt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (enable) state_next = ST_RUN;
      ST_RUN:      if (!enable) state_next = ST_STOPPING;
      ST_STOPPING: begin
        if (enable)          state_next = ST_RUN;
        else if (frame_last) state_next = ST_IDLE;
      end
      default:     state_next = ST_IDLE;
    endcase
  end

  // Counters start one cycle after leaving IDLE and stop on the same edge that re-enters IDLE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_active <= 1'b0;
    else     cnt_active <= (state != ST_IDLE) && (state_next != ST_IDLE);
  end

  assign sel_cur = at_origin ? pattern_e'(pattern_sel) : sel_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_q     <= PAT_H_RAMP;
      frame_cnt <= 8'h00;
    end else begin
      if (at_origin)  sel_q     <= pattern_e'(pattern_sel);
      if (frame_last) frame_cnt <= frame_cnt + 8'h01;
    end
  end

  assign de_d = cnt_active && h_active && v_active;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixel_out   <= 8'h00;
      de_out      <= 1'b0;
      h_sync_out  <= 1'b0;
      v_sync_out  <= 1'b0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      pixel_out   <= de_d ? pattern_pixel(sel_cur, h_lo, v_lo, frame_cnt) : 8'h00;
      de_out      <= de_d;
      h_sync_out  <= cnt_active && h_sync;
      v_sync_out  <= cnt_active && v_sync;
      frame_start <= cnt_active && at_origin;
      busy        <= (state != ST_IDLE);
    end
  end

  assign stream_out[PIX_MSB:PIX_LSB] = pixel_out;
  assign stream_out[DE_BIT]          = de_out;
  assign stream_out[HS_BIT]          = h_sync_out;
  assign stream_out[VS_BIT]          = v_sync_out;

endmodule

// File: tb/tb_video_stream_gen.sv
// tb/tb_video_stream_gen.sv - scoreboard bench for video_stream_gen on a 14x7 raster
module tb_video_stream_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  pattern_sel = 2'd0;
  logic [7:0]  pixel_out;
  logic        de_out, h_sync_out, v_sync_out, frame_start, busy;
  logic [10:0] stream_out;

  logic        enable_b = 1'b0;
  logic [7:0]  b_pixel;
  logic        b_de, b_hs, b_vs, b_fs, b_busy;
  logic [10:0] b_stream;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        wait_fs;
    logic [11:0] word;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  video_stream_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
    .pixel_out(pixel_out), .de_out(de_out), .h_sync_out(h_sync_out),
    .v_sync_out(v_sync_out), .frame_start(frame_start), .stream_out(stream_out),
    .busy(busy)
  );

  video_stream_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_wide (
    .clk(clk), .rst(rst), .enable(enable_b), .pattern_sel(2'd2),
    .pixel_out(b_pixel), .de_out(b_de), .h_sync_out(b_hs),
    .v_sync_out(b_vs), .frame_start(b_fs), .stream_out(b_stream),
    .busy(b_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] exp_word(input int sel, input int fc, input int h, input int v);
    logic de, hs, vs, fs;
    logic [7:0] pix;
    de = (h < 8) && (v < 4);
    hs = (h >= 10) && (h < 12);
    vs = (v == 5);
    fs = (h == 0) && (v == 0);
    case (sel)
      0:       pix = 8'(h);
      1:       pix = 8'(v);
      2:       pix = ((((h >> 3) ^ (v >> 3)) & 1) != 0) ? 8'hFF : 8'h00;
      default: pix = 8'(h + fc);
    endcase
    if (!de) pix = 8'h00;
    return {fs, pix, de, hs, vs};
  endfunction

  task automatic push_frame(input int sel, input int fc, input logic wait_fs);
    for (int v = 0; v < 7; v++) begin
      for (int h = 0; h < 14; h++) begin
        exp_t e;
        e.wait_fs = wait_fs && (h == 0) && (v == 0);
        e.word    = exp_word(sel, fc, h, v);
        exp_q.push_back(e);
      end
    end
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({frame_start, busy, stream_out, pixel_out, de_out, h_sync_out, v_sync_out});
  endfunction

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin : monitor
    int   waited;
    exp_t e;
    waited = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        if (exp_q[0].wait_fs && !frame_start) begin
          waited++;
          if (waited > 300) begin
            total++;
            bad++;
            $display("FAIL frame_start_timeout: frame_start=%b, required 1 within 300 cycles", frame_start);
            exp_q.delete();
            waited = 0;
          end
        end else begin
          waited = 0;
          e = exp_q.pop_front();
          check("stream_word", 32'({frame_start, pixel_out, de_out, h_sync_out, v_sync_out}), 32'(e.word));
          check("stream_packed", 32'(stream_out), 32'(e.word[10:0]));
        end
      end
    end
  end

  initial begin : stimulus
    logic found;

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", all_outputs(), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // run unchecked into mid-frame, then hit reset between clock edges
    @(negedge clk);
    enable = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("busy_running", 32'(busy), 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_zero", all_outputs(), 32'd0);
    enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("idle_after_reset", all_outputs(), 32'd0);
    end

    // frames 0 and 1 back-to-back; pattern_sel moves mid-frame each time
    @(negedge clk);
    pattern_sel = 2'd0;
    push_frame(0, 0, 1'b1);
    push_frame(1, 1, 1'b0);
    enable = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("start_e1", 32'({frame_start, de_out}), 32'd0);
    @(posedge clk);
    #1;
    check("start_e2", 32'({frame_start, de_out, busy}), 32'h7);
    repeat (20) @(posedge clk);
    @(negedge clk);
    pattern_sel = 2'd1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    pattern_sel = 2'd2;
    enable = 1'b0;
    wait_empty("drain_ab");
    @(posedge clk);
    #1;
    check("stopped_ab", all_outputs(), 32'd0);

    // frames 2 and 3: stop mid-frame, re-enable on the final STOPPING cycle
    @(negedge clk);
    pattern_sel = 2'd3;
    push_frame(3, 2, 1'b1);
    push_frame(3, 3, 1'b0);
    enable = 1'b1;
    @(posedge clk);
    repeat (30) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    repeat (68) @(posedge clk);
    @(negedge clk);
    enable = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    enable = 1'b0;
    wait_empty("drain_cd");
    @(posedge clk);
    #1;
    check("stopped_cd", all_outputs(), 32'd0);

    // 16-wide checker on the second instance
    @(negedge clk);
    enable_b = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(posedge clk);
      #1;
      if (b_fs) found = 1'b1;
    end
    check("wide_frame_start", 32'(found), 32'd1);
    for (int i = 0; i < 16; i++) begin
      check("wide_checker_pixel", 32'(b_pixel), (i < 8) ? 32'h00 : 32'hFF);
      @(posedge clk);
      #1;
    end
    enable_b = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
